// File: rtl/verisynth_pkg.sv
// Shared types and tables for the polyphonic voice allocator.
package verisynth_pkg;

  localparam int unsigned NUM_VOICES = 8;
  localparam int unsigned VoiceIdxW  = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    StIdle,
    StAttack,
    StSustain,
    StRelease
  } voice_state_e;

  typedef logic [3:0] note_t;

  typedef struct packed {
    logic  valid;
    note_t note;
  } note_lookup_t;

  // PS/2 set-2 scancode to note index (0 = C4 .. 12 = C5).
  function automatic note_lookup_t scancode_to_note(input logic [7:0] sc);
    note_lookup_t r;
    r.valid = 1'b1;
    case (sc)
      8'h1C:   r.note = 4'd0;
      8'h1D:   r.note = 4'd1;
      8'h1B:   r.note = 4'd2;
      8'h24:   r.note = 4'd3;
      8'h23:   r.note = 4'd4;
      8'h2B:   r.note = 4'd5;
      8'h2C:   r.note = 4'd6;
      8'h34:   r.note = 4'd7;
      8'h35:   r.note = 4'd8;
      8'h33:   r.note = 4'd9;
      8'h3C:   r.note = 4'd10;
      8'h3B:   r.note = 4'd11;
      8'h42:   r.note = 4'd12;
      default: begin
        r.valid = 1'b0;
        r.note  = 4'd0;
      end
    endcase
    return r;
  endfunction

  // Equal-tempered pitch, A4 = 440 Hz, unsigned Q16.16.
  function automatic logic [31:0] base_freq(input note_t n);
    case (n)
      4'd0:    return 32'h0105A025;
      4'd1:    return 32'h01152EC1;
      4'd2:    return 32'h0125AA2E;
      4'd3:    return 32'h01372082;
      4'd4:    return 32'h0149A0A8;
      4'd5:    return 32'h015D3A6D;
      4'd6:    return 32'h0171FE92;
      4'd7:    return 32'h0187FED5;
      4'd8:    return 32'h019F4E01;
      4'd9:    return 32'h01B80000;
      4'd10:   return 32'h01D229EC;
      4'd11:   return 32'h01EDE220;
      4'd12:   return 32'h020B404A;
      default: return 32'h0;
    endcase
  endfunction

  // Octave shift: left for positive octaves, truncating right for negative ones.
  function automatic logic [31:0] scale_octave(input logic [31:0] base,
                                               input logic signed [2:0] oct);
    case (oct)
      3'sd1:   return base << 1;
      3'sd2:   return base << 2;
      -3'sd1:  return base >> 1;
      -3'sd2:  return base >> 2;
      default: return base;
    endcase
  endfunction

endpackage

// File: rtl/voice_envelope.sv
// One voice: key/note register plus linear attack/release envelope.
module voice_envelope
  import verisynth_pkg::*;
#(
  parameter logic [15:0] ATTACK_STEP  = 16'h0800,
  parameter logic [15:0] RELEASE_STEP = 16'h0200
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         tick_i,
  input  logic         load_i,
  input  note_t        note_i,
  input  logic         release_i,
  output voice_state_e state_o,
  output note_t        note_o,
  output logic [15:0]  level_o
);

  voice_state_e state_q;
  note_t        note_q;
  logic [15:0]  level_q;
  logic [16:0]  attack_sum;
  logic [15:0]  attack_lvl;
  logic [15:0]  release_lvl;

  // Saturating next levels for a tick.
  always_comb begin
    attack_sum  = {1'b0, level_q} + {1'b0, ATTACK_STEP};
    attack_lvl  = attack_sum[16] ? 16'hFFFF : attack_sum[15:0];
    release_lvl = (level_q > RELEASE_STEP) ? (level_q - RELEASE_STEP) : 16'h0000;
  end

  // Envelope FSM; a key event in the same cycle as a tick suppresses the tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      note_q  <= '0;
      level_q <= '0;
    end else if (load_i) begin
      state_q <= StAttack;
      note_q  <= note_i;
      level_q <= '0;
    end else if (release_i) begin
      if (state_q == StAttack || state_q == StSustain) state_q <= StRelease;
    end else if (tick_i) begin
      case (state_q)
        StAttack: begin
          level_q <= attack_lvl;
          if (attack_lvl == 16'hFFFF) state_q <= StSustain;
        end
        StRelease: begin
          level_q <= release_lvl;
          if (release_lvl == 16'h0000) state_q <= StIdle;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;
  assign note_o  = note_q;
  assign level_o = level_q;

endmodule

// File: rtl/voice_allocator.sv
// PS/2 key events -> 8 polyphonic voices with octave shift and 1 ms envelopes.
module voice_allocator
  import verisynth_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 1536000,
  parameter logic [15:0] ATTACK_STEP  = 16'h0800,
  parameter logic [15:0] RELEASE_STEP = 16'h0200
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [10:0]                  ps2_key,
  output logic [NUM_VOICES-1:0][31:0]  frequencies,
  output logic [NUM_VOICES-1:0][31:0]  voice_volumes,
  output logic signed [2:0]            octave
);

  localparam int unsigned TickDiv = CLK_HZ / 1000;
  localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  logic                        toggle_q;
  logic [TickW-1:0]            tick_cnt_q;
  logic [VoiceIdxW-1:0]        steal_ptr_q;
  logic signed [2:0]           octave_q;
  logic [NUM_VOICES-1:0][31:0] freq_q, freq_d;
  logic [NUM_VOICES-1:0][31:0] vol_q, vol_d;

  logic                        tick;
  logic                        key_valid;
  logic                        pressed;
  logic                        note_evt;
  note_lookup_t                key_note;
  logic                        oct_dn, oct_up;

  voice_state_e                v_state [NUM_VOICES];
  note_t                       v_note  [NUM_VOICES];
  logic [15:0]                 v_level [NUM_VOICES];

  logic [NUM_VOICES-1:0]       held;
  logic                        any_held;
  logic [VoiceIdxW-1:0]        alloc_idx;
  logic                        alloc_steal;
  logic                        do_alloc;
  logic [NUM_VOICES-1:0]       load;
  logic [NUM_VOICES-1:0]       rel_req;

  // An event is any change of the toggle bit; extended-prefix keys are never used.
  assign key_valid = (ps2_key[10] ^ toggle_q) & ~ps2_key[8];
  assign pressed   = ps2_key[9];
  assign key_note  = scancode_to_note(ps2_key[7:0]);
  assign note_evt  = key_valid & key_note.valid;
  assign oct_dn    = key_valid & pressed & (ps2_key[7:0] == 8'h1A);
  assign oct_up    = key_valid & pressed & (ps2_key[7:0] == 8'h22);
  assign tick      = (tick_cnt_q == TickW'(TickDiv - 1));

  // Which voices currently hold the event's note as a sounding (not releasing) key.
  always_comb begin
    held = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      held[i] = (v_state[i] == StAttack || v_state[i] == StSustain) &&
                (v_note[i] == key_note.note);
    end
  end
  assign any_held = |held;

  // Victim choice: lowest idle, else lowest releasing, else round-robin steal.
  always_comb begin
    alloc_idx   = steal_ptr_q;
    alloc_steal = 1'b1;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (v_state[i] == StRelease) begin
        alloc_idx   = VoiceIdxW'(i);
        alloc_steal = 1'b0;
      end
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (v_state[i] == StIdle) begin
        alloc_idx   = VoiceIdxW'(i);
        alloc_steal = 1'b0;
      end
    end
  end

  // Typematic repeats of a sounding key must not spawn a second voice.
  assign do_alloc = note_evt & pressed & ~any_held;

  // Per-voice load and release strobes.
  always_comb begin
    load    = '0;
    rel_req = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      load[i]    = do_alloc && (alloc_idx == VoiceIdxW'(i));
      rel_req[i] = note_evt && !pressed && held[i];
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    voice_envelope #(
      .ATTACK_STEP  (ATTACK_STEP),
      .RELEASE_STEP (RELEASE_STEP)
    ) u_env (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .tick_i    (tick),
      .load_i    (load[gi]),
      .note_i    (key_note.note),
      .release_i (rel_req[gi]),
      .state_o   (v_state[gi]),
      .note_o    (v_note[gi]),
      .level_o   (v_level[gi])
    );
  end

  // Control state: event toggle, ms tick divider, steal pointer, octave.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q    <= 1'b0;
      tick_cnt_q  <= '0;
      steal_ptr_q <= '0;
      octave_q    <= '0;
    end else begin
      toggle_q   <= ps2_key[10];
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
      if (do_alloc && alloc_steal) steal_ptr_q <= steal_ptr_q + VoiceIdxW'(1);
      if (oct_dn && octave_q > -3'sd2) octave_q <= octave_q - 3'sd1;
      else if (oct_up && octave_q < 3'sd2) octave_q <= octave_q + 3'sd1;
    end
  end

  // Idle voices are silent with zero pitch; releasing voices keep their pitch.
  always_comb begin
    freq_d = '0;
    vol_d  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (v_state[i] != StIdle) begin
        freq_d[i] = scale_octave(base_freq(v_note[i]), octave_q);
        vol_d[i]  = {16'h0000, v_level[i]};
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_q <= '0;
      vol_q  <= '0;
    end else begin
      freq_q <= freq_d;
      vol_q  <= vol_d;
    end
  end

  assign frequencies   = freq_q;
  assign voice_volumes = vol_q;
  assign octave        = octave_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed and random key traffic against a behavioural voice-pool model.
module tb_voice_allocator;

  localparam int unsigned ClkHz   = 16000;
  localparam int unsigned TickDiv = ClkHz / 1000;
  localparam int          MIdle = 0, MAtk = 1, MSus = 2, MRel = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [10:0]       ps2_key = '0;
  logic [7:0][31:0]  frequencies;
  logic [7:0][31:0]  voice_volumes;
  logic signed [2:0] octave;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int               m_st [8];
  int               m_lvl [8];
  logic [7:0]       m_sc [8];
  int               m_oct, m_cnt, m_steal;
  logic             m_tog;
  logic [7:0][31:0] m_freq, m_vol;

  voice_allocator #(
    .CLK_HZ       (ClkHz),
    .ATTACK_STEP  (16'h0800),
    .RELEASE_STEP (16'h0200)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .frequencies   (frequencies),
    .voice_volumes (voice_volumes),
    .octave        (octave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic longint base_of(input logic [7:0] sc);
    case (sc)
      8'h1C: return 64'h0105A025;  8'h1D: return 64'h01152EC1;
      8'h1B: return 64'h0125AA2E;  8'h24: return 64'h01372082;
      8'h23: return 64'h0149A0A8;  8'h2B: return 64'h015D3A6D;
      8'h2C: return 64'h0171FE92;  8'h34: return 64'h0187FED5;
      8'h35: return 64'h019F4E01;  8'h33: return 64'h01B80000;
      8'h3C: return 64'h01D229EC;  8'h3B: return 64'h01EDE220;
      8'h42: return 64'h020B404A;
      default: return 0;
    endcase
  endfunction

  function automatic longint pitch(input logic [7:0] sc, input int oct);
    if (oct >= 0) return base_of(sc) * (64'd1 << oct);
    return base_of(sc) / (64'd1 << (-oct));
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 8; v++) begin
      m_st[v] = MIdle; m_lvl[v] = 0; m_sc[v] = 8'h00;
    end
    m_oct = 0; m_cnt = 0; m_steal = 0; m_tog = 1'b0;
    m_freq = '0; m_vol = '0;
  endtask

  task automatic model_step();
    logic [7:0][31:0] nf, nv;
    bit   touched [8];
    bit   tick;
    int   tgt;
    bit   holding;
    logic [7:0] sc;
    // Outputs follow the state as it stood before this edge.
    for (int v = 0; v < 8; v++) begin
      touched[v] = 1'b0;
      nf[v] = (m_st[v] == MIdle) ? 32'h0 : 32'(pitch(m_sc[v], m_oct));
      nv[v] = (m_st[v] == MIdle) ? 32'h0 : 32'(m_lvl[v]);
    end
    tick  = (m_cnt == TickDiv - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    sc    = ps2_key[7:0];
    if (ps2_key[10] != m_tog && !ps2_key[8]) begin
      if (ps2_key[9] && sc == 8'h1A && m_oct > -2) m_oct--;
      if (ps2_key[9] && sc == 8'h22 && m_oct < 2) m_oct++;
      if (base_of(sc) != 0) begin
        holding = 1'b0;
        for (int v = 0; v < 8; v++)
          if ((m_st[v] == MAtk || m_st[v] == MSus) && m_sc[v] == sc) begin
            holding = 1'b1;
            if (!ps2_key[9]) begin m_st[v] = MRel; touched[v] = 1'b1; end
          end
        if (ps2_key[9] && !holding) begin
          tgt = -1;
          for (int v = 0; v < 8; v++) if (m_st[v] == MIdle) begin tgt = v; break; end
          if (tgt < 0)
            for (int v = 0; v < 8; v++) if (m_st[v] == MRel) begin tgt = v; break; end
          if (tgt < 0) begin tgt = m_steal; m_steal = (m_steal + 1) % 8; end
          m_st[tgt] = MAtk; m_lvl[tgt] = 0; m_sc[tgt] = sc; touched[tgt] = 1'b1;
        end
      end
    end
    m_tog = ps2_key[10];
    if (tick)
      for (int v = 0; v < 8; v++) begin
        if (touched[v]) continue;
        if (m_st[v] == MAtk) begin
          m_lvl[v] = (m_lvl[v] + 'h800 > 'hFFFF) ? 'hFFFF : m_lvl[v] + 'h800;
          if (m_lvl[v] == 'hFFFF) m_st[v] = MSus;
        end else if (m_st[v] == MRel) begin
          m_lvl[v] = (m_lvl[v] < 'h200) ? 0 : m_lvl[v] - 'h200;
          if (m_lvl[v] == 0) m_st[v] = MIdle;
        end
      end
    m_freq = nf;
    m_vol  = nv;
  endtask

  // Model advances on the same edges as the design.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check_eq("freq_bus", frequencies, m_freq);
      check_eq("vol_bus", voice_volumes, m_vol);
      check_eq("octave", {253'b0, octave}, {253'b0, 3'(m_oct)});
    end
  end

  task automatic send(input bit p, input bit ext, input logic [7:0] sc);
    @(negedge clk);
    ps2_key = {~ps2_key[10], p, ext, sc};
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ps2_key = '0;
    idle(3);
    reset_n = 1'b1;
  endtask

  logic [7:0] fill_seq [10] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23,
                               8'h2B, 8'h2C, 8'h34, 8'h35, 8'h33};
  logic [7:0] rnd_sc [16] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
                             8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h1A, 8'h22, 8'h15};

  initial begin
    bit found;
    idle(2);
    check_eq("rst_freq", frequencies, '0);
    check_eq("rst_vol", voice_volumes, '0);
    check_eq("rst_oct", {253'b0, octave}, '0);
    reset_n = 1'b1;

    // Ignored events: extended prefix and unmapped scancode.
    send(1'b1, 1'b1, 8'h33); idle(2);
    check_eq("ext_ignored", frequencies[0], 32'h0);
    send(1'b1, 1'b0, 8'h15); idle(2);
    check_eq("unmapped_ignored", frequencies[0], 32'h0);

    // A4 press: two-cycle latency, attack to full level, then release to silence.
    send(1'b1, 1'b0, 8'h33);
    idle(1);
    check_eq("a4_n1", frequencies[0], 32'h0);
    idle(1);
    check_eq("a4_n2", frequencies[0], 32'h01B80000);
    idle(34 * TickDiv);
    check_eq("a4_full", voice_volumes[0], 32'h0000FFFF);
    send(1'b0, 1'b0, 8'h33);
    idle(10 * TickDiv);
    check_eq("rel_keeps_freq", frequencies[0], 32'h01B80000);
    idle(125 * TickDiv);
    check_eq("rel_vol0", voice_volumes[0], 32'h0);
    check_eq("rel_freq0", frequencies[0], 32'h0);

    // Octave up/down with saturation.
    send(1'b1, 1'b0, 8'h22); idle(2);
    check_eq("oct_up1", {253'b0, octave}, 256'd1);
    send(1'b1, 1'b0, 8'h33); idle(2);
    check_eq("a4_oct1", frequencies[0], 32'h03700000);
    send(1'b1, 1'b0, 8'h22); idle(1);
    send(1'b1, 1'b0, 8'h22); idle(2);
    check_eq("oct_sat_hi", {253'b0, octave}, 256'd2);
    check_eq("a4_oct2", frequencies[0], 32'h06E00000);
    for (int k = 0; k < 5; k++) begin send(1'b1, 1'b0, 8'h1A); idle(1); end
    send(1'b0, 1'b0, 8'h22); idle(2);
    check_eq("oct_sat_lo", {253'b0, octave}, {253'b0, 3'b110});
    check_eq("a4_octm2", frequencies[0], 32'h006E0000);

    // Fill all voices, then steal 0 and 1 in turn.
    do_reset();
    for (int k = 0; k < 9; k++) begin send(1'b1, 1'b0, fill_seq[k]); idle(1); end
    idle(1);
    check_eq("steal_v0", frequencies[0], 32'h019F4E01);
    send(1'b1, 1'b0, fill_seq[9]); idle(2);
    check_eq("steal_v1", frequencies[1], 32'h01B80000);
    check_eq("v2_kept", frequencies[2], 32'h0125AA2E);

    // Typematic repeats allocate a single voice.
    do_reset();
    for (int k = 0; k < 5; k++) begin send(1'b1, 1'b0, 8'h1C); idle(3); end
    check_eq("rep_v0", frequencies[0], 32'h0105A025);
    check_eq("rep_v1_idle", frequencies[1], 32'h0);
    send(1'b0, 1'b0, 8'h1C);
    idle(3 * TickDiv);
    check_eq("rep_rel_freq", frequencies[0], 32'h0105A025);
    idle(40 * TickDiv);
    check_eq("rep_done", voice_volumes[0], 32'h0);

    // Asynchronous reset mid-attack.
    do_reset();
    send(1'b1, 1'b0, 8'h1C);
    found = 1'b0;
    for (int c = 0; c < 20 * TickDiv && !found; c++) begin
      @(negedge clk);
      if (voice_volumes[0] == 32'h00004000) found = 1'b1;
    end
    check_eq("reach_4000", {255'b0, found}, 256'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_freq", frequencies, '0);
    check_eq("async_vol", voice_volumes, '0);
    check_eq("async_oct", {253'b0, octave}, '0);
    ps2_key = '0;
    idle(2);
    reset_n = 1'b1;
    send(1'b1, 1'b0, 8'h1D); idle(2);
    check_eq("post_rst_v0", frequencies[0], 32'h01152EC1);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      send(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           rnd_sc[$urandom_range(0, 15)]);
      idle($urandom_range(0, 3 * TickDiv));
    end
    idle(200 * TickDiv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1536000: input clock rate in Hz.
REQ-002 SHALL have parameter ATTACK_STEP, default 16'h0800: level increment per envelope tick.
REQ-003 SHALL have parameter RELEASE_STEP, default 16'h0200: level decrement per envelope tick.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ps2_key  in  11  key event: [10] toggles once per event, [9] pressed, [8] extended, [7:0] scancode.
REQ-007 SHALL have port frequencies  out  8x32  per-voice pitch, Hz in unsigned Q16.16, consumed by Synthesizer.
REQ-008 SHALL have port voice_volumes  out  8x32  per-voice level, {16'h0, level[15:0]}.
REQ-009 SHALL have port octave  out  3  signed current octave shift, -2..+2.

Function
REQ-010 SHALL detect an event when ps2_key[10] differs from its value registered on the previous cycle, capturing [9:0] in that cycle (cycle N).
REQ-011 SHALL ignore events with ps2_key[8]=1 and events whose scancode is unmapped.
REQ-012 SHALL map 13 scancodes to notes: 1C C4, 1D C#4, 1B D4, 24 D#4, 23 E4, 2B F4, 2C F#4, 34 G4, 35 G#4, 33 A4, 3C A#4, 3B B4, 42 C5.
REQ-013 SHALL decrement octave on press of 1A (Z) and increment it on press of 22 (X), saturating at -2 and +2; releases of 1A/22 are ignored.
REQ-014 SHALL compute frequency as base table value shifted left by octave when positive and right by -octave when negative, truncating.
REQ-015 Per-voice state machine SHALL be IDLE -> ATTACK (key press assigned) -> SUSTAIN (level reaches 16'hFFFF) -> RELEASE (key's break event) -> IDLE (level reaches 0).
REQ-016 A break received during ATTACK SHALL move the voice directly to RELEASE from its current level.
REQ-017 On press, a key already held by a voice in ATTACK or SUSTAIN SHALL be ignored, so typematic repeats create no new voice.
REQ-018 On a new press, allocation SHALL choose the lowest-index IDLE voice; else the lowest-index RELEASE voice; else the voice at steal_ptr, after which steal_ptr increments mod 8.
REQ-019 An allocated voice SHALL load its key, set level to 0 and enter ATTACK, including when the voice is stolen.
REQ-020 A break SHALL affect only the voice holding that key in ATTACK or SUSTAIN; otherwise it is ignored.
REQ-021 Envelope tick SHALL pulse once every CLK_HZ/1000 cycles, giving 1 ms.
REQ-022 On each tick, ATTACK SHALL add ATTACK_STEP saturating at 16'hFFFF, and RELEASE SHALL subtract RELEASE_STEP saturating at 0.
REQ-023 When a tick and a key event target the same voice in the same cycle, the key event SHALL win and the tick SHALL be skipped for that voice only.
REQ-024 Frequency and volume outputs SHALL be registered; a key event detected in cycle N SHALL be visible on outputs in cycle N+2.
REQ-025 A voice in IDLE SHALL output frequency 0 and volume 0; a voice in RELEASE SHALL keep its frequency.
REQ-026 An octave change SHALL take effect on all non-IDLE voices within 2 cycles.

Reset
REQ-027 reset_n low SHALL clear all outputs to 0 and set octave to 0, all voices to IDLE, steal_ptr to 0, the tick counter to 0, and the toggle register to 0.
REQ-028 Assertion of reset_n mid-envelope SHALL take effect immediately, with no partial update.

Structure
REQ-029 Package verisynth_pkg SHALL hold NUM_VOICES=8, the voice-state enum, the scancode-to-note table, and the Q16.16 base-frequency table.
REQ-030 The per-voice envelope (state and level) SHALL be the sub-module voice_envelope, instantiated NUM_VOICES times; allocation and octave logic stay in voice_allocator.

Verification
REQ-031 Press 33 (A4), octave 0 -> voice0 frequency 32'h01B80000 at N+2; volume reaches 32'h0000FFFF after 32 ticks; state SUSTAIN.
REQ-032 Press 22, then press 33 -> octave=1 and voice0 frequency 32'h03700000; a third press of 22 with octave already +2 leaves octave=2.
REQ-033 Break 33 from SUSTAIN -> voice0 volume decreases by 0x200 per tick and reaches 0 in 128 ticks, then frequency is 0.
REQ-034 Nine distinct presses with none released -> voices 0-7 filled in order; the ninth steals voice0 (level 0, ATTACK), and a tenth steals voice1.
REQ-035 Repeat press 1C five times without break -> only one voice allocated; a single break moves it to RELEASE.
REQ-036 Pull reset_n low during ATTACK with level 0x4000 -> all outputs 0 in the same cycle; after release, the next press allocates voice0.
